convert_double_to_single_control_system: RTL and testbench
==========================================================

# convert_double_to_single_control_system

Pipelined converter from extended-single floating point (43 bit: 1 sign, 11 exponent, 31 mantissa, bias 1023) back to IEEE single (32 bit). It is the return path of the control-system math chain: control-loop results computed in extended single are narrowed here before they go to single-precision consumers. The block is fully in-house RTL with no vendor IP. Throughput is one conversion per clock, latency is 3 clocks, and `done_sig` marks each result.

## Interface
Parameters:
- `LATENCY`, 3, pipeline depth. Fixed; changing it is not supported.
- `BIAS_DIFF`, 896, input bias minus output bias (1023 − 127).

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `sta` input 1: input-valid strobe; `x` is sampled on the same edge.
- `x` input `EXTENDED_SINGLE` (43): packed as {sign, exp[10:0], man[30:0]}.
- `y` output `SINGLE` (32): packed as {sign, exp[7:0], man[22:0]}; held until the next result.
- `done_sig` output 1: one-cycle pulse when `y` holds a new result.

## Operation
- Stage 1, unpack and classify:
  - zero/denormal when e_in = 0;
  - special when e_in = 0x7FF;
  - otherwise normal, with 12-bit signed eb = e_in − 896.
- Stage 2, round to nearest even on the 31→23 mantissa:
  - lsb = m[8], guard = m[7], sticky = OR of m[6:0].
  - Increment when guard & (sticky | lsb).
  - A carry out of the 23-bit field clears the mantissa and increments eb.
- Stage 3, range check and pack:
  - eb ≥ 255 → signed infinity (exp 0xFF, man 0).
  - eb ≤ 0 → signed zero. Flush-to-zero: no single denormals are produced.
  - Input zero/denormal → signed zero.
  - Input infinity (man = 0) → signed infinity.
  - Input NaN → 0x7FC00000 (canonical, sign discarded).
  - Otherwise pack {s, eb[7:0], rounded man}.
- The sign always passes through, except for NaN.
- The valid bit travels in a 3-deep shift register next to the data. `y` is loaded only when the stage-3 valid bit is 1; otherwise it holds its previous value.

## Timing
- Reset values: `y` = 0x00000000 and `done_sig` = 0. All stage registers and valid bits clear on the first clock edge with `rst` = 1.
- Latency: `sta` on edge N → `y` valid and `done_sig` = 1 after edge N+3, for exactly one cycle per accepted input.
- Back-to-back `sta` every cycle is legal. Results emerge in order, one per cycle, with `done_sig` held high for the run.
- Idle gaps produce no `done_sig`, and `y` keeps the last result.
- Reset mid-operation: in-flight conversions are discarded with no `done_sig`. A `sta` on the same edge as `rst` is ignored.
- No backpressure exists; the consumer must accept every `done_sig` pulse.

## Structure
- Add to the shared global parameter file:
  - `EXTENDED_SINGLE` = 43 and `SINGLE` = 32;
  - exponent and mantissa widths for both formats;
  - the biases 1023/127;
  - the canonical NaN constant 0x7FC00000.
- One sub-module, `fp_round_rne`: combinational round-to-nearest-even on a parameterised mantissa width, outputting the rounded mantissa and a carry. It is used in stage 2.

## Test plan
- **Simple values.** s=0, e=1023, m=0 → 0x3F800000 with `done_sig` exactly 3 cycles after `sta`. s=1, same fields → 0xBF800000.
- **Rounding.**
  - e=1023, m=0x00000080 (tie, lsb 0) → 0x3F800000.
  - m=0x00000180 (tie, lsb 1) → 0x3F800002.
  - m=0x000000C0 (above half) → 0x3F800001.
- **Overflow.**
  - e=1151 → 0x7F800000.
  - e=1150, m=all ones → rounds up to inf 0x7F800000.
  - e=1150, m=0 → 0x7F000000.
- **Underflow and specials.**
  - e=896 → 0x00000000.
  - s=1, e=0, m≠0 → 0x80000000.
  - e=0x7FF, m=0, s=1 → 0xFF800000.
  - e=0x7FF, m=1 → 0x7FC00000.
- **Streaming.** 8 consecutive `sta` carrying 1.0, 2.0, …, 8.0 → 8 consecutive `done_sig` cycles with 0x3F800000, 0x40000000, …, 0x41000000 in order. A following idle gap holds `y` at 0x41000000.
- **Reset mid-stream.** Assert `rst` for 1 cycle while 3 conversions are in flight → no `done_sig` for them and `y` = 0. The next `sta` converts normally with latency 3.

Source files
------------

// File: rtl/convert_double_to_single_control_system_pkg.sv
// Shared format constants for the extended-single to single narrowing path.
package convert_double_to_single_control_system_pkg;

    localparam int EXTENDED_SINGLE = 43;
    localparam int SINGLE          = 32;

    localparam int EXT_EXP_W = 11;
    localparam int EXT_MAN_W = 31;
    localparam int SGL_EXP_W = 8;
    localparam int SGL_MAN_W = 23;

    localparam int EXT_BIAS = 1023;
    localparam int SGL_BIAS = 127;

    localparam logic [SINGLE-1:0] CANON_NAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        CLS_ZERO    = 2'd0,
        CLS_SPECIAL = 2'd1,
        CLS_NORMAL  = 2'd2
    } fp_class_e;

    function automatic fp_class_e classify_exp(input logic [EXT_EXP_W-1:0] exp_in);
        fp_class_e cls;
        if (exp_in == 11'h000) begin
            cls = CLS_ZERO;
        end else if (exp_in == 11'h7FF) begin
            cls = CLS_SPECIAL;
        end else begin
            cls = CLS_NORMAL;
        end
        return cls;
    endfunction

endpackage

// File: rtl/convert_double_to_single_control_system_fp_round_rne.sv
// Combinational round-to-nearest-even from IN_W to OUT_W mantissa bits.
module fp_round_rne #(
    parameter int IN_W  = 31,
    parameter int OUT_W = 23
) (
    input  logic [IN_W-1:0]  man_i,
    output logic [OUT_W-1:0] man_o,
    output logic             carry_o
);

    localparam int DROP = IN_W - OUT_W;

    logic             lsb_s;
    logic             guard_s;
    logic             sticky_s;
    logic             inc_s;
    logic [OUT_W:0]   sum_s;

    // Ties go to the even neighbour; an all-ones field wraps to zero with carry.
    always_comb begin
        lsb_s    = man_i[DROP];
        guard_s  = man_i[DROP-1];
        sticky_s = |man_i[DROP-2:0];
        inc_s    = guard_s & (sticky_s | lsb_s);
        sum_s    = {1'b0, man_i[IN_W-1 -: OUT_W]} + {{OUT_W{1'b0}}, inc_s};
        man_o    = sum_s[OUT_W-1:0];
        carry_o  = sum_s[OUT_W];
    end

endmodule

// File: rtl/convert_double_to_single_control_system.sv
// Three-stage extended-single to IEEE single converter with valid tracking.
module convert_double_to_single_control_system
    import convert_double_to_single_control_system_pkg::*;
#(
    parameter int LATENCY   = 3,
    parameter int BIAS_DIFF = EXT_BIAS - SGL_BIAS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sta,
    input  logic [EXTENDED_SINGLE-1:0] x,
    output logic [SINGLE-1:0]          y,
    output logic                       done_sig
);

    logic [LATENCY-1:0]    valid_q, valid_d;

    fp_class_e             s1_cls_q, s1_cls_d;
    logic                  s1_sign_q, s1_sign_d;
    logic [EXT_MAN_W-1:0]  s1_man_q, s1_man_d;
    logic signed [11:0]    s1_eb_q, s1_eb_d;

    fp_class_e             s2_cls_q, s2_cls_d;
    logic                  s2_sign_q, s2_sign_d;
    logic                  s2_nan_q, s2_nan_d;
    logic [SGL_MAN_W-1:0]  s2_man_q, s2_man_d;
    logic signed [11:0]    s2_eb_q, s2_eb_d;

    logic [SINGLE-1:0]     s3_y_q, s3_y_d;
    logic [SINGLE-1:0]     y_q, y_d;
    logic                  done_q, done_d;

    logic [EXT_EXP_W-1:0]  exp_in_s;
    logic [SGL_MAN_W-1:0]  rnd_man_s;
    logic                  rnd_carry_s;

    // Stage 1: unpack fields, classify and rebias the exponent.
    always_comb begin
        exp_in_s  = x[EXTENDED_SINGLE-2 -: EXT_EXP_W];
        s1_sign_d = x[EXTENDED_SINGLE-1];
        s1_man_d  = x[EXT_MAN_W-1:0];
        s1_cls_d  = classify_exp(exp_in_s);
        s1_eb_d   = 12'({1'b0, exp_in_s}) - 12'(BIAS_DIFF);
    end

    fp_round_rne #(
        .IN_W  (EXT_MAN_W),
        .OUT_W (SGL_MAN_W)
    ) u_round (
        .man_i   (s1_man_q),
        .man_o   (rnd_man_s),
        .carry_o (rnd_carry_s)
    );

    // Stage 2: round mantissa and fold the rounding carry into the exponent.
    always_comb begin
        s2_cls_d  = s1_cls_q;
        s2_sign_d = s1_sign_q;
        s2_nan_d  = |s1_man_q;
        s2_man_d  = rnd_man_s;
        s2_eb_d   = s1_eb_q + {11'd0, rnd_carry_s};
    end

    // Stage 3: range check and pack; denormal results flush to signed zero.
    always_comb begin
        s3_y_d = 32'h0000_0000;
        case (s2_cls_q)
            CLS_ZERO: begin
                s3_y_d = {s2_sign_q, 31'd0};
            end
            CLS_SPECIAL: begin
                if (s2_nan_q) begin
                    s3_y_d = CANON_NAN;
                end else begin
                    s3_y_d = {s2_sign_q, 8'hFF, 23'd0};
                end
            end
            CLS_NORMAL: begin
                if (s2_eb_q >= 12'sd255) begin
                    s3_y_d = {s2_sign_q, 8'hFF, 23'd0};
                end else if (s2_eb_q <= 12'sd0) begin
                    s3_y_d = {s2_sign_q, 31'd0};
                end else begin
                    s3_y_d = {s2_sign_q, s2_eb_q[7:0], s2_man_q};
                end
            end
            default: begin
                s3_y_d = 32'h0000_0000;
            end
        endcase
    end

    // Output load and valid shift; y holds between results.
    always_comb begin
        valid_d = {valid_q[LATENCY-2:0], sta};
        done_d  = valid_q[LATENCY-1];
        if (valid_q[LATENCY-1]) begin
            y_d = s3_y_q;
        end else begin
            y_d = y_q;
        end
    end

    // Pipeline registers with synchronous reset that also drops a coincident sta.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= '0;
            s1_cls_q  <= CLS_ZERO;
            s1_sign_q <= 1'b0;
            s1_man_q  <= '0;
            s1_eb_q   <= 12'sd0;
            s2_cls_q  <= CLS_ZERO;
            s2_sign_q <= 1'b0;
            s2_nan_q  <= 1'b0;
            s2_man_q  <= '0;
            s2_eb_q   <= 12'sd0;
            s3_y_q    <= 32'h0000_0000;
            y_q       <= 32'h0000_0000;
            done_q    <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            s1_cls_q  <= s1_cls_d;
            s1_sign_q <= s1_sign_d;
            s1_man_q  <= s1_man_d;
            s1_eb_q   <= s1_eb_d;
            s2_cls_q  <= s2_cls_d;
            s2_sign_q <= s2_sign_d;
            s2_nan_q  <= s2_nan_d;
            s2_man_q  <= s2_man_d;
            s2_eb_q   <= s2_eb_d;
            s3_y_q    <= s3_y_d;
            y_q       <= y_d;
            done_q    <= done_d;
        end
    end

    assign y        = y_q;
    assign done_sig = done_q;

endmodule

// File: tb/tb_convert_double_to_single_control_system.sv
// Directed-vector bench for the extended-single to single converter.
module tb_convert_double_to_single_control_system;

    logic        clk = 1'b0;
    logic        rst;
    logic        sta;
    logic [42:0] x;
    logic [31:0] y;
    logic        done_sig;

    int n_checks = 0;
    int n_errors = 0;

    convert_double_to_single_control_system dut (
        .clk      (clk),
        .rst      (rst),
        .sta      (sta),
        .x        (x),
        .y        (y),
        .done_sig (done_sig)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One conversion: checks done is low after two edges and high with the result after three.
    task automatic run_conv(input string tag, input logic s, input logic [10:0] e,
                            input logic [30:0] m, input logic [31:0] exp_y);
        @(negedge clk);
        sta = 1'b1;
        x   = {s, e, m};
        @(negedge clk);
        sta = 1'b0;
        x   = '0;
        @(negedge clk);
        @(negedge clk);
        check_eq({tag, "_done_early"}, {31'd0, done_sig}, 32'd0);
        @(negedge clk);
        check_eq({tag, "_done"}, {31'd0, done_sig}, 32'd1);
        check_eq({tag, "_y"}, y, exp_y);
    endtask

    logic [10:0] st_e [8];
    logic [30:0] st_m [8];
    logic [31:0] st_y [8];

    initial begin
        st_e = '{11'd1023, 11'd1024, 11'd1024, 11'd1025, 11'd1025, 11'd1025, 11'd1025, 11'd1026};
        st_m = '{31'h0, 31'h0, 31'h4000_0000, 31'h0, 31'h2000_0000, 31'h4000_0000, 31'h6000_0000, 31'h0};
        st_y = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                 32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};

        rst = 1'b1;
        sta = 1'b0;
        x   = '0;
        @(negedge clk);
        @(negedge clk);
        check_eq("reset_y", y, 32'h0000_0000);
        check_eq("reset_done", {31'd0, done_sig}, 32'd0);
        rst = 1'b0;

        run_conv("one_pos",   1'b0, 11'd1023, 31'h0,          32'h3F80_0000);
        run_conv("one_neg",   1'b1, 11'd1023, 31'h0,          32'hBF80_0000);
        run_conv("tie_even",  1'b0, 11'd1023, 31'h0000_0080,  32'h3F80_0000);
        run_conv("tie_odd",   1'b0, 11'd1023, 31'h0000_0180,  32'h3F80_0002);
        run_conv("above_hf",  1'b0, 11'd1023, 31'h0000_00C0,  32'h3F80_0001);
        run_conv("ovf_exp",   1'b0, 11'd1151, 31'h0,          32'h7F80_0000);
        run_conv("ovf_round", 1'b0, 11'd1150, 31'h7FFF_FFFF,  32'h7F80_0000);
        run_conv("max_exp",   1'b0, 11'd1150, 31'h0,          32'h7F00_0000);
        run_conv("ufl",       1'b0, 11'd896,  31'h0,          32'h0000_0000);
        run_conv("denorm_n",  1'b1, 11'd0,    31'h0000_1234,  32'h8000_0000);
        run_conv("inf_neg",   1'b1, 11'h7FF,  31'h0,          32'hFF80_0000);
        run_conv("nan",       1'b1, 11'h7FF,  31'h1,          32'h7FC0_0000);

        // Streaming: input i driven at iteration i, its result visible at iteration i+4.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (i >= 4 && i < 12) begin
                check_eq($sformatf("stream_done%0d", i - 4), {31'd0, done_sig}, 32'd1);
                check_eq($sformatf("stream_y%0d", i - 4), y, st_y[i-4]);
            end else if (i >= 12) begin
                check_eq($sformatf("idle_done%0d", i), {31'd0, done_sig}, 32'd0);
                check_eq($sformatf("idle_y%0d", i), y, 32'h4100_0000);
            end else if (i >= 1) begin
                check_eq($sformatf("stream_pre%0d", i), {31'd0, done_sig}, 32'd0);
            end
            if (i < 8) begin
                sta = 1'b1;
                x   = {1'b0, st_e[i], st_m[i]};
            end else begin
                sta = 1'b0;
                x   = '0;
            end
        end

        // Reset with three conversions in flight plus a coincident sta.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sta = 1'b1;
            x   = {1'b0, 11'd1024, 31'h0};
        end
        @(negedge clk);
        rst = 1'b1;
        sta = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sta = 1'b0;
        x   = '0;
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("rst_done%0d", i), {31'd0, done_sig}, 32'd0);
            check_eq($sformatf("rst_y%0d", i), y, 32'h0000_0000);
            @(negedge clk);
        end
        run_conv("after_rst", 1'b0, 11'd1025, 31'h0, 32'h4080_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
